// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (ICache / DCache) cache-line arbiter in front of a
// single memory port. One transaction is in flight at a time:
// IDLE -> CMD -> WDATA/RDATA -> IDLE.
//
// Optional feature macro: MEM_ARBITER_RR_EN
//   defined   : when both caches request together, the one not granted most
//               recently wins. A one-bit pointer flips on every grant.
//   undefined : DCache always wins a tie. No pointer register exists.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   ic_req_*                     ICache line-fill request (read only)
//   ic_resp_valid                read beat strobe for ICache
//   dc_req_*                     DCache request (rnw: 1 = fill, 0 = writeback)
//   dc_wdata_*                   DCache writeback beat stream
//   dc_resp_valid                read beat strobe for DCache
//   resp_data                    read beat data, shared by both caches
//   mem_req_*                    memory command channel
//   mem_wdata_*                  memory write beat channel
//   mem_resp_valid/data          memory read beat channel
module mem_arbiter #(
    parameter int DATA_W = 128,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ic_req_valid,
    output logic              ic_req_ready,
    input  logic [27:0]       ic_req_addr,
    output logic              ic_resp_valid,
    input  logic              dc_req_valid,
    output logic              dc_req_ready,
    input  logic              dc_req_rnw,
    input  logic [27:0]       dc_req_addr,
    input  logic              dc_wdata_valid,
    output logic              dc_wdata_ready,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_rnw,
    output logic [27:0]       mem_req_addr,
    output logic              mem_wdata_valid,
    input  logic              mem_wdata_ready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

    state_t           state_q, state_d;
    logic             owner_ic_q, owner_ic_d;
    logic [27:0]      addr_q, addr_d;
    logic             rnw_q, rnw_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    logic             grant_ic, grant_dc;
    logic             idle_ok;

    // Readies are combinational. Gating them with reset_n keeps every
    // handshake output low while reset is held, even if requests are asserted.
    assign idle_ok = (state_q == IDLE) && reset_n;

`ifdef MEM_ARBITER_RR_EN
    // prio_ic_q = 1 means ICache wins the next tie.
    logic prio_ic_q, prio_ic_d;

    always_comb begin
        grant_ic  = ic_req_valid && (!dc_req_valid || prio_ic_q);
        grant_dc  = dc_req_valid && (!ic_req_valid || !prio_ic_q);
        prio_ic_d = prio_ic_q;
        if (idle_ok && (grant_ic || grant_dc))
            prio_ic_d = grant_dc;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prio_ic_q <= 1'b0;
        else          prio_ic_q <= prio_ic_d;
    end
`else
    always_comb begin
        grant_dc = dc_req_valid;
        grant_ic = ic_req_valid && !dc_req_valid;
    end
`endif

    always_comb begin
        state_d         = state_q;
        owner_ic_d      = owner_ic_q;
        addr_d          = addr_q;
        rnw_d           = rnw_q;
        beat_d          = beat_q;
        ic_req_ready    = 1'b0;
        dc_req_ready    = 1'b0;
        ic_resp_valid   = 1'b0;
        dc_resp_valid   = 1'b0;
        resp_data       = '0;
        mem_req_valid   = 1'b0;
        mem_wdata_valid = 1'b0;
        dc_wdata_ready  = 1'b0;
        mem_wdata       = '0;

        case (state_q)
            IDLE: begin
                ic_req_ready = idle_ok && grant_ic;
                dc_req_ready = idle_ok && grant_dc;
                if (idle_ok && (grant_ic || grant_dc)) begin
                    owner_ic_d = grant_ic;
                    addr_d     = grant_ic ? ic_req_addr : dc_req_addr;
                    rnw_d      = grant_ic ? 1'b1 : dc_req_rnw;
                    state_d    = CMD;
                end
            end
            CMD: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = rnw_q ? RDATA : WDATA;
                end
            end
            WDATA: begin
                mem_wdata_valid = dc_wdata_valid;
                dc_wdata_ready  = mem_wdata_ready;
                mem_wdata       = dc_wdata;
                if (dc_wdata_valid && mem_wdata_ready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = IDLE;
                end
            end
            RDATA: begin
                resp_data     = mem_resp_data;
                ic_resp_valid = owner_ic_q && mem_resp_valid;
                dc_resp_valid = !owner_ic_q && mem_resp_valid;
                if (mem_resp_valid) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_ic_q <= 1'b0;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_ic_q <= owner_ic_d;
            addr_q     <= addr_d;
            rnw_q      <= rnw_d;
            beat_q     <= beat_d;
        end
    end

    assign mem_req_addr = addr_q;
    assign mem_req_rnw  = rnw_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int DATA_W = 128;
    localparam int BEATS  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              ic_req_valid, ic_req_ready, ic_resp_valid;
    logic [27:0]       ic_req_addr;
    logic              dc_req_valid, dc_req_ready, dc_req_rnw;
    logic [27:0]       dc_req_addr;
    logic              dc_wdata_valid, dc_wdata_ready, dc_resp_valid;
    logic [DATA_W-1:0] dc_wdata, resp_data;
    logic              mem_req_valid, mem_req_ready, mem_req_rnw;
    logic [27:0]       mem_req_addr;
    logic              mem_wdata_valid, mem_wdata_ready;
    logic [DATA_W-1:0] mem_wdata, mem_resp_data;
    logic              mem_resp_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk(clk), .reset_n(reset_n),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
        .ic_req_addr(ic_req_addr), .ic_resp_valid(ic_resp_valid),
        .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
        .dc_req_rnw(dc_req_rnw), .dc_req_addr(dc_req_addr),
        .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
        .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid),
        .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rnw(mem_req_rnw), .mem_req_addr(mem_req_addr),
        .mem_wdata_valid(mem_wdata_valid), .mem_wdata_ready(mem_wdata_ready),
        .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
    );

    function automatic logic [DATA_W-1:0] pat(input int b);
        pat = {32'(b), 32'hDEADBEEF, 32'(b * 3 + 1), 32'h12345678};
    endfunction

    // Stimulus only: quiet inputs, hold reset for two edges, release on a negedge.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rnw = 0; dc_req_addr = '0;
        dc_wdata_valid = 0; dc_wdata = '0;
        mem_req_ready = 0; mem_wdata_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        ic_req_valid = 1; dc_req_valid = 1; mem_resp_valid = 1; mem_req_ready = 1;
        #1;
        checks++;
        if ({ic_req_ready, dc_req_ready, mem_req_valid, mem_wdata_valid,
             dc_wdata_ready, ic_resp_valid, dc_resp_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {ic_req_ready, dc_req_ready, mem_req_valid, mem_wdata_valid,
                      dc_wdata_ready, ic_resp_valid, dc_resp_valid});
        end
        checks++;
        if (mem_req_addr !== 28'h0 || mem_req_rnw !== 1'b0) begin
            errors++;
            $display("FAIL reset_addr_rnw: got %h/%b expected 0/0", mem_req_addr, mem_req_rnw);
        end
        do_reset();
    endtask

    task automatic test_ic_read();
        int pulses = 0;
        do_reset();
        @(negedge clk);
        ic_req_valid = 1; ic_req_addr = 28'h0000040;
        #1;
        checks++;
        if (ic_req_ready !== 1'b1 || dc_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL ic_grant: ic_ready=%b dc_ready=%b expected 1/0", ic_req_ready, dc_req_ready);
        end
        // CMD, memory stalls one cycle; request still held must not be re-granted
        @(negedge clk);
        #1;
        checks++;
        if (ic_req_ready !== 1'b0 || mem_req_valid !== 1'b1 ||
            mem_req_addr !== 28'h0000040 || mem_req_rnw !== 1'b1) begin
            errors++;
            $display("FAIL ic_cmd: ready=%b valid=%b addr=%h rnw=%b expected 0/1/0000040/1",
                     ic_req_ready, mem_req_valid, mem_req_addr, mem_req_rnw);
        end
        // CMD accept, with a stray response beat that must be ignored
        @(negedge clk);
        ic_req_valid = 0; mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = pat(99);
        #1;
        checks++;
        if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0 || mem_req_valid !== 1'b1) begin
            errors++;
            $display("FAIL ic_cmd_stray_resp: ic_resp=%b dc_resp=%b mreq=%b expected 0/0/1",
                     ic_resp_valid, dc_resp_valid, mem_req_valid);
        end
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b0 || ic_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL ic_rdata_entry: mreq=%b ic_resp=%b expected 0/0", mem_req_valid, ic_resp_valid);
        end
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            mem_resp_valid = 1; mem_resp_data = pat(b);
            #1;
            if (ic_resp_valid === 1'b1) pulses++;
            checks++;
            if (ic_resp_valid !== 1'b1 || dc_resp_valid !== 1'b0 || resp_data !== pat(b)) begin
                errors++;
                $display("FAIL ic_beat%0d: ic=%b dc=%b data=%h expected 1/0/%h",
                         b, ic_resp_valid, dc_resp_valid, resp_data, pat(b));
            end
            if (b != BEATS - 1) begin
                @(negedge clk);
                mem_resp_valid = 0;
                #1;
                checks++;
                if (ic_resp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL ic_gap%0d: ic_resp=%b expected 0", b, ic_resp_valid);
                end
            end
        end
        // Back in IDLE: a stray beat produces nothing
        @(negedge clk);
        mem_resp_valid = 1; mem_resp_data = pat(7);
        #1;
        checks++;
        if (ic_resp_valid !== 1'b0 || dc_resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || pulses != BEATS) begin
            errors++;
            $display("FAIL ic_done: ic=%b dc=%b mreq=%b pulses=%0d expected 0/0/0/4",
                     ic_resp_valid, dc_resp_valid, mem_req_valid, pulses);
        end
        mem_resp_valid = 0;
    endtask

    task automatic test_dc_write();
        int hs = 0;
        do_reset();
        @(negedge clk);
        dc_req_valid = 1; dc_req_rnw = 0; dc_req_addr = 28'h0ABCDEF;
        #1;
        checks++;
        if (dc_req_ready !== 1'b1 || ic_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL dc_grant: dc=%b ic=%b expected 1/0", dc_req_ready, ic_req_ready);
        end
        @(negedge clk);
        dc_req_valid = 0; mem_req_ready = 1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h0ABCDEF || mem_req_rnw !== 1'b0) begin
            errors++;
            $display("FAIL dc_cmd: valid=%b addr=%h rnw=%b expected 1/0abcdef/0",
                     mem_req_valid, mem_req_addr, mem_req_rnw);
        end
        for (int b = 0; b < BEATS; b++) begin
            for (int s = 0; s < 3; s++) begin
                @(negedge clk);
                mem_req_ready = 0;
                dc_wdata_valid = 1; dc_wdata = pat(b + 10);
                mem_wdata_ready = (s == 2);
                #1;
                if (mem_wdata_valid && mem_wdata_ready) hs++;
                checks++;
                if (mem_wdata_valid !== 1'b1 || mem_wdata !== pat(b + 10) ||
                    dc_wdata_ready !== (s == 2)) begin
                    errors++;
                    $display("FAIL dc_wbeat%0d_s%0d: mvalid=%b data=%h ready=%b expected 1/%h/%0d",
                             b, s, mem_wdata_valid, mem_wdata, dc_wdata_ready, pat(b + 10), (s == 2));
                end
            end
        end
        // An extra offered beat after the line must not be consumed
        @(negedge clk);
        dc_wdata_valid = 1; mem_wdata_ready = 1; dc_wdata = pat(50);
        #1;
        checks++;
        if (mem_wdata_valid !== 1'b0 || dc_wdata_ready !== 1'b0 || mem_req_valid !== 1'b0 || hs != BEATS) begin
            errors++;
            $display("FAIL dc_write_done: mvalid=%b ready=%b mreq=%b beats=%0d expected 0/0/0/4",
                     mem_wdata_valid, dc_wdata_ready, mem_req_valid, hs);
        end
        dc_wdata_valid = 0; mem_wdata_ready = 0;
    endtask

    task automatic test_priority();
        do_reset();
        @(negedge clk);
        ic_req_valid = 1; ic_req_addr = 28'h0000111;
        dc_req_valid = 1; dc_req_rnw = 1; dc_req_addr = 28'h0000222;
        #1;
        checks++;
        if (dc_req_ready !== 1'b1 || ic_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL prio_tie: dc=%b ic=%b expected 1/0", dc_req_ready, ic_req_ready);
        end
        @(negedge clk);
        dc_req_valid = 0; mem_req_ready = 1;
        #1;
        checks++;
        if (ic_req_ready !== 1'b0 || mem_req_addr !== 28'h0000222 || mem_req_rnw !== 1'b1) begin
            errors++;
            $display("FAIL prio_cmd: ic_ready=%b addr=%h rnw=%b expected 0/0000222/1",
                     ic_req_ready, mem_req_addr, mem_req_rnw);
        end
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = pat(b + 20);
            #1;
            checks++;
            if (dc_resp_valid !== 1'b1 || ic_resp_valid !== 1'b0 || ic_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL prio_beat%0d: dc=%b ic=%b ic_ready=%b expected 1/0/0",
                         b, dc_resp_valid, ic_resp_valid, ic_req_ready);
            end
        end
        @(negedge clk);
        mem_resp_valid = 0;
        #1;
        checks++;
        if (ic_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL prio_ic_after: ic_ready=%b expected 1", ic_req_ready);
        end
        @(negedge clk);
        ic_req_valid = 0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h0000111) begin
            errors++;
            $display("FAIL prio_ic_cmd: mreq=%b addr=%h expected 1/0000111", mem_req_valid, mem_req_addr);
        end
    endtask

    // Both requesters held valid; each transaction is IDLE, CMD, 4 x RDATA.
    task automatic test_back_to_back();
        logic exp_ic [4];
`ifdef MEM_ARBITER_RR_EN
        exp_ic = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ic = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        @(negedge clk);
        ic_req_valid = 1; ic_req_addr = 28'h0000300;
        dc_req_valid = 1; dc_req_rnw = 1; dc_req_addr = 28'h0000400;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = pat(5);
        for (int k = 0; k < 4 * (BEATS + 2); k++) begin
            if (k != 0) @(negedge clk);
            #1;
            if (k % (BEATS + 2) == 0) begin
                checks++;
                if (ic_req_ready !== exp_ic[k / (BEATS + 2)] ||
                    dc_req_ready !== !exp_ic[k / (BEATS + 2)]) begin
                    errors++;
                    $display("FAIL b2b_grant%0d: ic=%b dc=%b expected ic=%b",
                             k / (BEATS + 2), ic_req_ready, dc_req_ready, exp_ic[k / (BEATS + 2)]);
                end
            end else if (k % (BEATS + 2) >= 2) begin
                checks++;
                if (ic_resp_valid !== exp_ic[k / (BEATS + 2)] ||
                    dc_resp_valid !== !exp_ic[k / (BEATS + 2)]) begin
                    errors++;
                    $display("FAIL b2b_resp_k%0d: ic=%b dc=%b expected ic=%b",
                             k, ic_resp_valid, dc_resp_valid, exp_ic[k / (BEATS + 2)]);
                end
            end
        end
        ic_req_valid = 0; dc_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        ic_req_valid = 1; ic_req_addr = 28'h0000040;
        @(negedge clk);
        ic_req_valid = 0; mem_req_ready = 1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = pat(b);
            #1;
            checks++;
            if (ic_resp_valid !== 1'b1) begin
                errors++;
                $display("FAIL rst_mid_beat%0d: ic_resp=%b expected 1", b, ic_resp_valid);
            end
        end
        @(negedge clk);
        reset_n = 0; ic_req_valid = 1; mem_resp_valid = 1;
        #1;
        checks++;
        if ({ic_req_ready, dc_req_ready, mem_req_valid, mem_wdata_valid,
             dc_wdata_ready, ic_resp_valid, dc_resp_valid} !== 7'b0 || mem_req_addr !== 28'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b addr=%h expected 0000000 addr=0",
                     {ic_req_ready, dc_req_ready, mem_req_valid, mem_wdata_valid,
                      dc_wdata_ready, ic_resp_valid, dc_resp_valid}, mem_req_addr);
        end
        @(negedge clk);
        reset_n = 1; ic_req_valid = 0; mem_resp_valid = 0;
        @(negedge clk);
        dc_req_valid = 1; dc_req_rnw = 1; dc_req_addr = 28'h0000055;
        #1;
        checks++;
        if (dc_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_after_grant: dc_ready=%b expected 1", dc_req_ready);
        end
        @(negedge clk);
        dc_req_valid = 0; mem_req_ready = 1;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h0000055 || mem_req_rnw !== 1'b1) begin
            errors++;
            $display("FAIL rst_after_cmd: mreq=%b addr=%h rnw=%b expected 1/0000055/1",
                     mem_req_valid, mem_req_addr, mem_req_rnw);
        end
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clk);
            mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = pat(b + 30);
            #1;
            checks++;
            if (dc_resp_valid !== 1'b1 || ic_resp_valid !== 1'b0 || resp_data !== pat(b + 30)) begin
                errors++;
                $display("FAIL rst_after_beat%0d: dc=%b ic=%b data=%h expected 1/0/%h",
                         b, dc_resp_valid, ic_resp_valid, resp_data, pat(b + 30));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (dc_resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_after_done: dc_resp=%b expected 0", dc_resp_valid);
        end
        mem_resp_valid = 0;
    endtask

    initial begin
        reset_n = 0;
        ic_req_valid = 0; ic_req_addr = '0;
        dc_req_valid = 0; dc_req_rnw = 0; dc_req_addr = '0;
        dc_wdata_valid = 0; dc_wdata = '0;
        mem_req_ready = 0; mem_wdata_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0;
        test_reset();
        test_ic_read();
        test_dc_write();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameters: DATA_W, default 128, beat width in bits; BEATS, default 4, beats per cache-line transfer (power of 2, >=2).
REQ-002 SHALL provide these ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ic_req_valid  in  1  ICache line-fill request (read only).
- ic_req_ready  out  1  ICache request accepted this cycle.
- ic_req_addr  in  28  ICache line address.
- ic_resp_valid  out  1  read beat valid for ICache.
- dc_req_valid  in  1  DCache request.
- dc_req_ready  out  1  DCache request accepted this cycle.
- dc_req_rnw  in  1  1=line fill, 0=writeback.
- dc_req_addr  in  28  DCache line address.
- dc_wdata_valid  in  1  DCache writeback beat valid.
- dc_wdata_ready  out  1  writeback beat consumed.
- dc_wdata  in  DATA_W  writeback beat data.
- dc_resp_valid  out  1  read beat valid for DCache.
- resp_data  out  DATA_W  read beat data, shared by both caches.
- mem_req_valid  out  1  memory command valid.
- mem_req_ready  in  1  memory command accepted.
- mem_req_rnw  out  1  command direction.
- mem_req_addr  out  28  command line address.
- mem_wdata_valid  out  1  write beat valid to memory.
- mem_wdata_ready  in  1  memory accepts write beat.
- mem_wdata  out  DATA_W  write beat data.
- mem_resp_valid  in  1  memory read beat valid.
- mem_resp_data  in  DATA_W  memory read beat data.

Function
REQ-003 SHALL implement FSM states IDLE, CMD, WDATA, RDATA; one transaction outstanding at a time.
REQ-004 In IDLE, SHALL grant at most one requester per cycle: assert its req_ready combinationally for exactly that cycle, latch owner, addr and rnw (rnw=1 for ICache), then go to CMD; with no valid request, SHALL stay in IDLE.
REQ-005 With both requests valid in IDLE, SHALL grant DCache (fixed priority), unless REQ-014 applies.
REQ-006 req_ready SHALL be 0 in every state other than IDLE.
REQ-007 In CMD, SHALL hold mem_req_valid=1 with latched addr/rnw stable until mem_req_ready; on handshake SHALL go to RDATA if rnw=1, else WDATA.
REQ-008 In WDATA: mem_wdata_valid=dc_wdata_valid, dc_wdata_ready=mem_wdata_ready, mem_wdata=dc_wdata; both handshake outputs 0 in other states.
REQ-009 SHALL count beats with a log2(BEATS)-bit counter, cleared on entry to WDATA/RDATA and incremented per handshake (write) or per mem_resp_valid (read); on beat BEATS-1 SHALL return to IDLE next cycle.
REQ-010 In RDATA, resp_data=mem_resp_data and owner's resp_valid=mem_resp_valid, zero latency; non-owner resp_valid SHALL be 0.
REQ-011 SHALL ignore mem_resp_valid outside RDATA (no resp_valid asserted).
REQ-012 A new grant SHALL be possible on the first IDLE cycle after a transfer completes (one bubble minimum between transactions).

Reset
REQ-013 On reset_n=0, asynchronously and mid-transaction: state=IDLE, beat counter=0, owner=DCache, round-robin pointer=DCache, all valid/ready outputs 0, latched addr/rnw=0; in-flight transfer abandoned.

Configuration
REQ-014 Macro MEM_ARBITER_RR_EN: when defined, simultaneous requests SHALL be granted to the requester not granted most recently (pointer updated on every grant); when undefined, fixed DCache priority per REQ-005 and no pointer register.

Verification
REQ-015 ICache-only request to addr 0x0000040, BEATS=4 -> ic_req_ready 1 cycle, mem_req_addr=0x0000040 rnw=1, four ic_resp_valid pulses, dc_resp_valid never 1.
REQ-016 DCache writeback to addr 0x0ABCDEF with mem_wdata_ready low for 2 cycles per beat -> exactly 4 write beats in order, no lost/duplicate beats, then IDLE.
REQ-017 Both valid in the same cycle, macro undefined -> DCache granted; ICache granted on the first IDLE cycle after completion.
REQ-018 Both valid continuously, MEM_ARBITER_RR_EN defined -> grants alternate D, I, D, I over 4 transactions.
REQ-019 reset_n pulsed low after 2 read beats -> all outputs 0 immediately; after release, a new request completes all 4 beats normally.
REQ-020 mem_resp_valid asserted while in CMD -> no resp_valid output, beat counter still 0 on RDATA entry.
